// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// Module   : pipe_pkg
// Brief    : Opcode, ALU-control and instruction-field constants for the decode
//            stage, plus the ID/EX payload type.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam logic [3:0] c_OP_ADD  = 4'h0;
  localparam logic [3:0] c_OP_SUB  = 4'h1;
  localparam logic [3:0] c_OP_OR   = 4'h2;
  localparam logic [3:0] c_OP_AND  = 4'h3;
  localparam logic [3:0] c_OP_ADDI = 4'h4;
  localparam logic [3:0] c_OP_BR   = 4'h5;
  localparam logic [3:0] c_OP_NOP  = 4'hF;

  // Codes must match the EX-stage ALU
  localparam logic [1:0] c_ALU_ADD = 2'b00;
  localparam logic [1:0] c_ALU_SUB = 2'b01;
  localparam logic [1:0] c_ALU_OR  = 2'b10;
  localparam logic [1:0] c_ALU_AND = 2'b11;

  localparam int c_OP_MSB  = 31;
  localparam int c_OP_LSB  = 28;
  localparam int c_RD_MSB  = 27;
  localparam int c_RD_LSB  = 23;
  localparam int c_RS1_MSB = 22;
  localparam int c_RS1_LSB = 18;
  localparam int c_RS2_MSB = 17;
  localparam int c_RS2_LSB = 13;

  typedef struct packed {
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_ctrl;
    logic [4:0]  rd;
    logic        is_branch;
  } idex_t;

endpackage

`default_nettype wire

// File: rtl/id_hazard_tracker.sv
//------------------------------------------------------------------------------
// Module   : id_hazard_tracker
// Brief    : WB_DEPTH-deep shift of destination registers still in flight to the
//            register file; flags source registers that match a pending write.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_hazard_tracker #(
  parameter int WB_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] push_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       rs1_hit,
  output logic       rs2_hit
);

  logic [WB_DEPTH-1:0][4:0] r_pipe;

  generate
    if (WB_DEPTH > 1) begin : g_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= {r_pipe[WB_DEPTH-2:0], push_rd};
      end
    end else begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pipe <= '0;
        else     r_pipe <= push_rd;
      end
    end
  endgenerate

  // r0 is hard-wired, so it never produces a match
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (rs1 != 5'd0 && r_pipe[i] == rs1) rs1_hit = 1'b1;
      if (rs2 != 5'd0 && r_pipe[i] == rs2) rs2_hit = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_decode.sv
//------------------------------------------------------------------------------
// Module   : id_ex_decode
// Brief    : Combinational instruction decode feeding the ID/EX register, with
//            RAW interlock against in-flight writebacks and branch flush.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_decode
  import pipe_pkg::*;
#(
  parameter int WB_DEPTH = 2,
  parameter int IMM_W    = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_ctrl,
  output logic [4:0]  rd_out,
  output logic        is_branch,
  input  logic        flush
);

  logic [3:0]  w_op;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_sext;
  idex_t       w_dec;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_rs1_hit;
  logic        w_rs2_hit;
  logic        w_hazard;
  logic        w_xfer;
  logic        w_accept;
  logic [4:0]  w_push_rd;

  logic        r_valid;
  idex_t       r_out;

  assign w_op       = instr[c_OP_MSB:c_OP_LSB];
  assign w_rd       = instr[c_RD_MSB:c_RD_LSB];
  assign rs1_addr   = instr[c_RS1_MSB:c_RS1_LSB];
  assign rs2_addr   = instr[c_RS2_MSB:c_RS2_LSB];
  assign w_imm_sext = {{(32-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

  always_comb begin
    w_dec     = '0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_op)
      c_OP_ADD, c_OP_SUB, c_OP_OR, c_OP_AND: begin
        w_use_rs1      = 1'b1;
        w_use_rs2      = 1'b1;
        w_dec.alu_a    = rs1_data;
        w_dec.alu_b    = rs2_data;
        w_dec.rd       = w_rd;
        // Reg-reg opcodes are numbered in ALU-control order
        w_dec.alu_ctrl = w_op[1:0];
      end
      c_OP_ADDI: begin
        w_use_rs1      = 1'b1;
        w_dec.alu_a    = rs1_data;
        w_dec.alu_b    = w_imm_sext;
        w_dec.alu_ctrl = c_ALU_ADD;
        w_dec.rd       = w_rd;
      end
      c_OP_BR: begin
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
        w_dec.alu_a     = rs1_data;
        w_dec.alu_b     = rs2_data;
        w_dec.alu_ctrl  = c_ALU_SUB;
        w_dec.is_branch = 1'b1;
      end
      default: w_dec = '0;
    endcase
  end

  assign w_xfer    = r_valid & out_ready;
  assign w_push_rd = w_xfer ? r_out.rd : 5'd0;

  id_hazard_tracker #(
    .WB_DEPTH (WB_DEPTH)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .push_rd (w_push_rd),
    .rs1     (rs1_addr),
    .rs2     (rs2_addr),
    .rs1_hit (w_rs1_hit),
    .rs2_hit (w_rs2_hit)
  );

  // The op sitting in ID/EX has not entered the tracker yet, so check it too
  always_comb begin
    w_hazard = 1'b0;
    if (w_use_rs1 && rs1_addr != 5'd0 &&
        (w_rs1_hit || (r_valid && r_out.rd == rs1_addr)))
      w_hazard = 1'b1;
    if (w_use_rs2 && rs2_addr != 5'd0 &&
        (w_rs2_hit || (r_valid && r_out.rd == rs2_addr)))
      w_hazard = 1'b1;
  end

  assign in_ready = ~w_hazard & (~r_valid | out_ready) & ~flush;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_out   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_out   <= w_dec;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign alu_a     = r_out.alu_a;
  assign alu_b     = r_out.alu_b;
  assign alu_ctrl  = r_out.alu_ctrl;
  assign rd_out    = r_out.rd;
  assign is_branch = r_out.is_branch;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_decode.sv
//------------------------------------------------------------------------------
// Module   : tb_id_ex_decode
// Brief    : Directed and random checks of id_ex_decode against a reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_decode;

  localparam int WB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, flush, is_branch;
  logic [31:0] instr, rs1_data, rs2_data, alu_a, alu_b;
  logic [4:0]  rs1_addr, rs2_addr, rd_out;
  logic [1:0]  alu_ctrl;

  logic [31:0] rf [32];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  c;
    logic [4:0]  rd;
    logic        br;
    logic        u1;
    logic        u2;
  } exp_t;

  typedef struct {
    int r;
    int rem;
  } pend_t;

  bit    m_valid;
  exp_t  m_out;
  pend_t pend[$];

  id_ex_decode #(.WB_DEPTH(WB), .IMM_W(13)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .rd_out(rd_out), .is_branch(is_branch), .flush(flush)
  );

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(int op, int rd, int s1, int s2, int imm);
    logic [31:0] w;
    w = {op[3:0], rd[4:0], s1[4:0], s2[4:0], imm[12:0]};
    return w;
  endfunction

  function automatic exp_t model_dec(logic [31:0] ins);
    int          op;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] simm;
    exp_t        e;
    op   = int'(ins[31:28]);
    s1   = ins[22:18];
    s2   = ins[17:13];
    simm = ins[12] ? (32'hFFFF_E000 | {19'd0, ins[12:0]}) : {19'd0, ins[12:0]};
    e    = '0;
    if (op <= 3) begin
      e.a = rf[s1]; e.b = rf[s2]; e.c = 2'(op); e.rd = ins[27:23]; e.u1 = 1; e.u2 = 1;
    end else if (op == 4) begin
      e.a = rf[s1]; e.b = simm; e.c = 2'd0; e.rd = ins[27:23]; e.u1 = 1;
    end else if (op == 5) begin
      e.a = rf[s1]; e.b = rf[s2]; e.c = 2'd1; e.br = 1; e.u1 = 1; e.u2 = 1;
    end
    return e;
  endfunction

  function automatic bit blocked(logic [4:0] s);
    if (s == 0) return 0;
    if (m_valid && m_out.rd == s) return 1;
    foreach (pend[i]) if (pend[i].r == int'(s)) return 1;
    return 0;
  endfunction

  function automatic bit model_haz(logic [31:0] ins);
    exp_t e;
    e = model_dec(ins);
    return (e.u1 && blocked(ins[22:18])) || (e.u2 && blocked(ins[17:13]));
  endfunction

  // One clock cycle: drive at posedge+1, check at posedge+2, advance model at the edge
  task automatic cycle(input bit iv, input logic [31:0] ins, input bit ordy, input bit fl,
                       output bit acc, output bit obs_rdy);
    bit    exp_rdy;
    bit    xfer;
    exp_t  nxt;
    pend_t keep[$];
    in_valid = iv; instr = ins; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !model_haz(ins) && (!m_valid || ordy) && !fl;
    obs_rdy = in_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("alu_a", alu_a, m_out.a);
      chk("alu_b", alu_b, m_out.b);
      chk("alu_ctrl", {30'd0, alu_ctrl}, {30'd0, m_out.c});
      chk("rd_out", {27'd0, rd_out}, {27'd0, m_out.rd});
      chk("is_branch", {31'd0, is_branch}, {31'd0, m_out.br});
    end
    acc  = iv && exp_rdy;
    nxt  = model_dec(ins);
    xfer = m_valid && ordy;
    @(posedge clk);
    foreach (pend[i]) if (pend[i].rem > 1) keep.push_back('{pend[i].r, pend[i].rem - 1});
    pend = keep;
    if (xfer && m_out.rd != 0) pend.push_back('{int'(m_out.rd), WB});
    if (fl)        m_valid = 0;
    else if (acc) begin m_valid = 1; m_out = nxt; end
    else if (ordy) m_valid = 0;
    #1;
  endtask

  task automatic drain();
    bit a, r;
    repeat (4) cycle(0, 32'hF000_0000, 1, 0, a, r);
  endtask

  initial begin
    bit          acc, rdy;
    int          stalls;
    logic [31:0] cur;
    bit          have;

    rst = 1; in_valid = 0; instr = 0; out_ready = 0; flush = 0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[1] = 32'd5; rf[2] = 32'd7; rf[6] = 32'd10;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_ctrl", {30'd0, alu_ctrl}, 32'd0);
    chk("rst_rd", {27'd0, rd_out}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    m_valid = 0; m_out = '0;

    cycle(1, mk(0, 3, 1, 2, 0), 1, 0, acc, rdy);
    chk("add_a", alu_a, 32'd5);
    chk("add_b", alu_b, 32'd7);
    chk("add_ctrl", {30'd0, alu_ctrl}, 32'd0);
    chk("add_rd", {27'd0, rd_out}, 32'd3);
    chk("add_valid", {31'd0, out_valid}, 32'd1);

    cycle(1, mk(4, 4, 6, 0, 13'h1FFF), 1, 0, acc, rdy);
    chk("addi_a", alu_a, 32'd10);
    chk("addi_b", alu_b, 32'hFFFF_FFFF);
    chk("addi_ctrl", {30'd0, alu_ctrl}, 32'd0);
    cycle(1, mk(4, 4, 6, 0, 13'h0FFF), 1, 0, acc, rdy);
    chk("addi_pos_b", alu_b, 32'h0000_0FFF);
    cycle(1, mk(1, 7, 1, 2, 0), 1, 0, acc, rdy);
    chk("sub_ctrl", {30'd0, alu_ctrl}, 32'd1);
    cycle(1, mk(2, 8, 1, 2, 0), 1, 0, acc, rdy);
    chk("or_ctrl", {30'd0, alu_ctrl}, 32'd2);
    cycle(1, mk(3, 9, 1, 2, 0), 1, 0, acc, rdy);
    chk("and_ctrl", {30'd0, alu_ctrl}, 32'd3);

    // RAW interlock
    drain();
    cycle(1, mk(0, 3, 1, 2, 0), 1, 0, acc, rdy);
    stalls = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1, mk(1, 5, 3, 1, 0), 1, 0, acc, rdy);
      if (acc) break;
      stalls++;
    end
    chk("raw_stalls", stalls, WB + 1);
    chk("raw_sub_rd", {27'd0, rd_out}, 32'd5);

    // Backpressure
    drain();
    cycle(1, mk(0, 10, 1, 2, 0), 1, 0, acc, rdy);
    for (int k = 0; k < 4; k++) begin
      cycle(1, mk(2, 11, 1, 2, 0), 0, 0, acc, rdy);
      chk("bp_ready", {31'd0, rdy}, 32'd0);
      chk("bp_hold_rd", {27'd0, rd_out}, 32'd10);
    end
    cycle(1, mk(2, 11, 1, 2, 0), 1, 0, acc, rdy);
    chk("bp_next_rd", {27'd0, rd_out}, 32'd11);

    // Branch then flush
    drain();
    cycle(1, mk(5, 9, 1, 2, 0), 1, 0, acc, rdy);
    chk("br_flag", {31'd0, is_branch}, 32'd1);
    chk("br_rd", {27'd0, rd_out}, 32'd0);
    cycle(1, mk(0, 12, 0, 0, 0), 1, 1, acc, rdy);
    chk("flush_block", {31'd0, rdy}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    cycle(1, mk(0, 12, 0, 0, 0), 1, 0, acc, rdy);
    chk("br_nohaz", {31'd0, rdy}, 32'd1);

    // Random traffic
    have = 0; cur = 0;
    for (int n = 0; n < 400; n++) begin
      bit iv, ordy, fl;
      if (!have) begin
        cur  = mk($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom);
        have = 1;
      end
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      cycle(iv, cur, ordy, fl, acc, rdy);
      if (acc) have = 0;
    end

    // Asynchronous reset mid-stream
    cycle(1, mk(0, 3, 1, 2, 0), 0, 0, acc, rdy);
    cycle(1, mk(0, 4, 1, 2, 0), 0, 0, acc, rdy);
    #2 rst = 1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ctrl", {30'd0, alu_ctrl}, 32'd0);
    chk("arst_rd", {27'd0, rd_out}, 32'd0);
    m_valid = 0; m_out = '0; pend.delete();
    in_valid = 0; out_ready = 1;
    #3 rst = 0;
    @(posedge clk); #1;
    cycle(1, mk(0, 3, 1, 2, 0), 1, 0, acc, rdy);
    chk("post_rst_add_a", alu_a, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
